// File: rtl/sequence_det.sv
// Serial bit-pattern detector: flags each time the last PAT_LEN received bits equal PATTERN.
// Build option SEQDET_MEALY_EN: combinational Mealy output instead of the registered Moore pulse.
module sequence_det #(
    parameter int                 PAT_LEN = 4,
    parameter logic [PAT_LEN-1:0] PATTERN = 4'b1101,
    parameter bit                 OVERLAP = 1'b1
) (
    input  logic clk,
    input  logic x,
    input  logic reset,
    output logic z
);
    localparam int SW = $clog2(PAT_LEN + 1);
    localparam logic [SW-1:0] S0 = '0;
`ifdef SEQDET_MEALY_EN
    localparam int NUM_ST = PAT_LEN;
    localparam logic [SW-1:0] S_LAST = SW'(PAT_LEN - 1);
`else
    localparam int NUM_ST = PAT_LEN + 1;
    localparam logic [SW-1:0] MATCH = SW'(PAT_LEN);
`endif

    // Longest PATTERN prefix (up to max_len bits) that ends the history seq (newest bit in LSB).
    function automatic int longest_border(input int seq, input int max_len);
        int res;
        res = 0;
        for (int l = 1; l <= max_len; l++) begin
            if (((seq ^ (int'(PATTERN) >> (PAT_LEN - l))) & ((1 << l) - 1)) == 0)
                res = l;
        end
        return res;
    endfunction

    function automatic int advance(input int k, input logic b);
        int seq;
        int lim;
        seq = ((int'(PATTERN) >> (PAT_LEN - k)) << 1) | int'(b);
        lim = (k + 1 < PAT_LEN) ? k + 1 : PAT_LEN;
        return longest_border(seq, lim);
    endfunction

    function automatic int next_of(input int k, input logic b);
        int s;
`ifdef SEQDET_MEALY_EN
        // No MATCH state: a completed pattern lands directly on its post-match state.
        s = advance(k, b);
        if (s == PAT_LEN)
            s = OVERLAP ? longest_border(int'(PATTERN), PAT_LEN - 1) : 0;
`else
        if (k == PAT_LEN)
            s = OVERLAP ? advance(PAT_LEN, b) : advance(0, b);
        else
            s = advance(k, b);
`endif
        return s;
    endfunction

    logic [SW-1:0] nxt0 [NUM_ST];
    logic [SW-1:0] nxt1 [NUM_ST];

    for (genvar k = 0; k < NUM_ST; k++) begin : g_tab
        localparam int N0 = next_of(k, 1'b0);
        localparam int N1 = next_of(k, 1'b1);
        assign nxt0[k] = SW'(N0);
        assign nxt1[k] = SW'(N1);
    end

    logic [SW-1:0] state_q;
    logic [SW-1:0] state_d;

    always_comb begin
        state_d = S0;
        for (int k = 0; k < NUM_ST; k++) begin
            if (state_q == SW'(k))
                state_d = x ? nxt1[k] : nxt0[k];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset)
            state_q <= S0;
        else
            state_q <= state_d;
    end

`ifdef SEQDET_MEALY_EN
    assign z = reset && (state_q == S_LAST) && (x == PATTERN[0]);
`else
    logic z_q;

    // Dedicated flop keeps z glitch-free; it mirrors state_q == MATCH.
    always_ff @(posedge clk) begin
        if (!reset)
            z_q <= 1'b0;
        else
            z_q <= (state_d == MATCH);
    end

    assign z = z_q;
`endif

endmodule

// File: tb/tb_sequence_det.sv
// Bench for sequence_det: three instances driven by one serial stream, checked against a bit-history model.
// Honours SEQDET_MEALY_EN the same way as the design.
module tb_sequence_det;
    logic clk = 1'b0;
    logic x = 1'b0;
    logic reset = 1'b0;
    logic z0;
    logic z1;
    logic z2;

    always #5 clk = ~clk;

    sequence_det u0 (.clk(clk), .x(x), .reset(reset), .z(z0));
    sequence_det #(.PAT_LEN(4), .PATTERN(4'b1101), .OVERLAP(1'b0))
        u1 (.clk(clk), .x(x), .reset(reset), .z(z1));
    sequence_det #(.PAT_LEN(5), .PATTERN(5'b10101), .OVERLAP(1'b1))
        u2 (.clk(clk), .x(x), .reset(reset), .z(z2));

    int checks = 0;
    int errors = 0;
    int plen [3] = '{4, 4, 5};
    int pat  [3] = '{13, 13, 21};
    bit ovl  [3] = '{1'b1, 1'b0, 1'b1};
    int hist [3] = '{0, 0, 0};
    int cnt  [3] = '{0, 0, 0};
    bit pred [3];
    int pulses [3] = '{0, 0, 0};

    function automatic logic z_of(input int i);
        case (i)
            0:       return z0;
            1:       return z1;
            default: return z2;
        endcase
    endfunction

    task automatic check(input string tag, input int i, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s u%0d: z=%b expected %b", tag, i, obs, exp);
        end
        if (obs === 1'b1) pulses[i]++;
    endtask

    task automatic check_cnt(input string tag, input int i, input int exp);
        checks++;
        assert (pulses[i] == exp) else begin
            errors++;
            $error("FAIL %s u%0d: pulses=%0d expected %0d", tag, i, pulses[i], exp);
        end
    endtask

    // One serial bit: the model predicts a match when the last PAT_LEN bits since
    // reset (or since the previous match when overlap is off) equal the pattern.
    task automatic step(input string tag, input logic xv, input logic rv);
        @(negedge clk);
        x = xv;
        reset = rv;
        for (int i = 0; i < 3; i++)
            pred[i] = rv && (cnt[i] + 1 >= plen[i]) &&
                      ((((hist[i] << 1) | int'(xv)) & ((1 << plen[i]) - 1)) == pat[i]);
`ifdef SEQDET_MEALY_EN
        #1;
        for (int i = 0; i < 3; i++) check(tag, i, z_of(i), pred[i]);
`endif
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            if (!rv) begin
                cnt[i] = 0;
                hist[i] = 0;
            end else begin
                hist[i] = ((hist[i] << 1) | int'(xv)) & 255;
                cnt[i] = (cnt[i] < 8) ? cnt[i] + 1 : 8;
                if (pred[i] && !ovl[i]) cnt[i] = 0;
            end
        end
`ifndef SEQDET_MEALY_EN
        #1;
        for (int i = 0; i < 3; i++) check(tag, i, z_of(i), pred[i]);
`endif
    endtask

    task automatic clear_pulses();
        for (int i = 0; i < 3; i++) pulses[i] = 0;
    endtask

    bit t2 [5]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    bit t3 [10] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    bit t5 [7]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

    initial begin
        // T1: reset held low with x=1
        step("T1_rst", 1'b1, 1'b0);
        step("T1_rst", 1'b1, 1'b0);
        clear_pulses();

        // T2: 1101 then a trailing 0
        for (int k = 0; k < 5; k++) step("T2", t2[k], 1'b1);
        check_cnt("T2_pulses", 0, 1);
        check_cnt("T2_pulses", 1, 1);

        // T3/T4: overlapping stream
        step("T3_rst", 1'b0, 1'b0);
        clear_pulses();
        for (int k = 0; k < 10; k++) step("T3", t3[k], 1'b1);
        check_cnt("T3_overlap", 0, 2);
        check_cnt("T4_no_overlap", 1, 1);
        check_cnt("T3_pat10101", 2, 0);

        // T5: run of ones, then 0,1
        step("T5_rst", 1'b0, 1'b0);
        clear_pulses();
        for (int k = 0; k < 7; k++) step("T5", t5[k], 1'b1);
        check_cnt("T5_selfloop", 0, 1);

        // T6: reset mid-pattern, on the would-be final bit
        step("T6_rst", 1'b0, 1'b0);
        clear_pulses();
        step("T6", 1'b1, 1'b1);
        step("T6", 1'b1, 1'b1);
        step("T6", 1'b0, 1'b1);
        step("T6_rst_last", 1'b1, 1'b0);
        step("T6", 1'b0, 1'b1);
        step("T6", 1'b1, 1'b1);
        check_cnt("T6_discard", 0, 0);

        // 10101 on the long-pattern instance with overlap
        step("P5_rst", 1'b0, 1'b0);
        clear_pulses();
        for (int k = 0; k < 9; k++) step("P5", 1'((k + 1) % 2), 1'b1);
        check_cnt("P5_overlap", 2, 3);

        for (int n = 0; n < 3000; n++)
            step("RAND", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 39) != 0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
